// File: rtl/instr_encoder.sv
// Instruction encoder: packs MIPS-style fields into 32-bit words and
// streams them into instruction memory as a start/last bounded session.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              err_full
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        F_R,
        F_I,
        F_J
    } fmt_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    fmt_t        fmt;
    logic [5:0]  opc;
    logic [5:0]  funct;
    logic        legal;
    logic        is_shift;
    logic        is_jr;
    logic [31:0] word;
    logic        accept;

    assign in_ready = (state == S_RUN);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        legal    = 1'b1;
        fmt      = F_R;
        opc      = 6'h00;
        funct    = 6'h00;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        unique case (in_op)
            5'd0:  funct = 6'h20;
            5'd1:  funct = 6'h21;
            5'd2:  funct = 6'h22;
            5'd3:  funct = 6'h23;
            5'd4:  funct = 6'h24;
            5'd5:  funct = 6'h25;
            5'd6:  begin funct = 6'h00; is_shift = 1'b1; end
            5'd7:  begin funct = 6'h02; is_shift = 1'b1; end
            5'd8:  funct = 6'h2A;
            5'd9:  begin funct = 6'h08; is_jr = 1'b1; end
            5'd10: begin fmt = F_I; opc = 6'b001000; end
            5'd11: begin fmt = F_I; opc = 6'b001001; end
            5'd12: begin fmt = F_I; opc = 6'b001010; end
            5'd13: begin fmt = F_I; opc = 6'b001011; end
            5'd14: begin fmt = F_I; opc = 6'b001100; end
            5'd15: begin fmt = F_I; opc = 6'b001101; end
            5'd16: begin fmt = F_I; opc = 6'b011000; end
            5'd17: begin fmt = F_I; opc = 6'b011001; end
            5'd18: begin fmt = F_I; opc = 6'b011010; end
            5'd19: begin fmt = F_I; opc = 6'b011011; end
            5'd20: begin fmt = F_I; opc = 6'b011100; end
            // BLEQ skips 011101
            5'd21: begin fmt = F_I; opc = 6'b011110; end
            5'd22: begin fmt = F_J; opc = 6'b000010; end
            5'd23: begin fmt = F_J; opc = 6'b000011; end
            5'd24: begin fmt = F_I; opc = 6'b100011; end
            5'd25: begin fmt = F_I; opc = 6'b101011; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        word = 32'h0;
        unique case (fmt)
            F_I: word = {opc, in_rs, in_rt, in_imm};
            F_J: word = {opc, in_target};
            default: word = {6'b000000, in_rs,
                             is_jr ? 5'd0 : in_rt,
                             is_jr ? 5'd0 : in_rd,
                             is_shift ? in_shamt : 5'd0,
                             funct};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        ptr         <= base_addr;
                        count       <= '0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept && legal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= word;
                        ptr       <= ptr + 1'b1;
                        count     <= count + 1'b1;
                        if (in_last) begin
                            state <= S_DONE;
                        end else if (count == LAST_CNT) begin
                            err_full <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else if (accept) begin
                        err_illegal <= 1'b1;
                        if (in_last) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed sessions on an 8-bit and a 2-bit
// address instance, writes checked against a queue of expected words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  base8 = 8'h0;
    logic [1:0]  base2 = 2'h0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;

    logic        rdy8, we8, busy8, done8, eil8, efu8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic [8:0]  cnt8;
    logic        rdy2, we2, busy2, done2, eil2, efu2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  cnt2;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q8[$];
    wr_t q2[$];
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .base_addr(base8),
        .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wd8), .busy(busy8), .done(done8), .count(cnt8),
        .err_illegal(eil8), .err_full(efu8)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
        .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wd2), .busy(busy2), .done(done2), .count(cnt2),
        .err_illegal(eil2), .err_full(efu2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected", {24'h0, addr8}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q8.pop_front();
                chk("w8_addr", {24'h0, addr8}, {24'h0, e.a});
                chk("w8_data", wd8, e.d);
            end
        end
        if (we2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("w2_unexpected", {30'h0, addr2}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q2.pop_front();
                chk("w2_addr", {30'h0, addr2}, {24'h0, e.a});
                chk("w2_data", wd2, e.d);
            end
        end
    end

    // Drive one word for a cycle; push an expected write when exp_en.
    task automatic send(input int inst, input logic [4:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input logic exp_en,
                        input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        in_valid  = 1'b1;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
        if (exp_en) begin
            e.a = a;
            e.d = d;
            if (inst == 8) q8.push_back(e);
            else q2.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic go8(input logic [7:0] b);
        start8 = 1'b1;
        base8  = b;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go2(input logic [1:0] b);
        start2 = 1'b1;
        base2  = b;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_flags8", {26'h0, busy8, rdy8, done8, we8, eil8, efu8}, 0);
        chk("rst_addr8", {24'h0, addr8}, 0);
        chk("rst_data8", wd8, 0);
        chk("rst_cnt8", {23'h0, cnt8}, 0);
        chk("rst_flags2", {26'h0, busy2, rdy2, done2, we2, eil2, efu2}, 0);
        rst = 1'b0;
        @(negedge clk);

        // single ADD, shamt supplied but ignored
        go8(8'h10);
        chk("run_busy_rdy", {30'h0, busy8, rdy8}, 32'h3);
        send(8, 5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 1'b1,
             1'b1, 8'h10, 32'h0022_1820);
        chk("add_done", {31'h0, done8}, 1);
        chk("add_count", {23'h0, cnt8}, 1);
        chk("add_rdy_low", {31'h0, rdy8}, 0);
        idle(1);
        chk("post_done", {30'h0, done8, busy8}, 0);
        chk("cnt_held", {23'h0, cnt8}, 1);

        // back-to-back mixed formats
        go8(8'h20);
        send(8, 5'd10, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0,
             1'b1, 8'h20, 32'h2005_FFFF);
        send(8, 5'd22, 5'd3, 5'd3, 5'd3, 5'd3, 16'h0, 26'h40, 1'b0,
             1'b1, 8'h21, 32'h0800_0040);
        send(8, 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b0,
             1'b1, 8'h22, 32'h0C00_0040);
        send(8, 5'd24, 5'd29, 5'd8, 5'd0, 5'd0, 16'h4, 26'h0, 1'b0,
             1'b1, 8'h23, 32'h8FA8_0004);
        send(8, 5'd6, 5'd0, 5'd4, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0,
             1'b1, 8'h24, 32'h0004_10C0);
        send(8, 5'd9, 5'd31, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0, 1'b0,
             1'b1, 8'h25, 32'h03E0_0008);
        send(8, 5'd25, 5'd29, 5'd8, 5'd0, 5'd0, 16'h4, 26'h0, 1'b1,
             1'b1, 8'h26, 32'hAFA8_0004);
        chk("b2b_done", {31'h0, done8}, 1);
        chk("b2b_count", {23'h0, cnt8}, 7);
        idle(1);

        // illegal op mid-session, stray start ignored
        go8(8'h40);
        send(8, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0,
             1'b1, 8'h40, 32'h0022_1820);
        start8 = 1'b1;
        base8  = 8'h99;
        send(8, 5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0,
             1'b0, 8'h0, 32'h0);
        start8 = 1'b0;
        chk("ill_flag", {31'h0, eil8}, 1);
        chk("ill_count", {23'h0, cnt8}, 1);
        chk("ill_no_we", {31'h0, we8}, 0);
        send(8, 5'd21, 5'd1, 5'd2, 5'd0, 5'd0, 16'h10, 26'h0, 1'b1,
             1'b1, 8'h41, 32'h7822_0010);
        chk("ill_done", {30'h0, done8, eil8}, 32'h3);
        chk("ill_cnt2", {23'h0, cnt8}, 2);
        idle(1);
        chk("ill_sticky", {31'h0, eil8}, 1);
        go8(8'h48);
        chk("ill_clr", {31'h0, eil8}, 0);
        send(8, 5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1,
             1'b0, 8'h0, 32'h0);
        chk("ill_last_done", {30'h0, done8, eil8}, 32'h3);
        chk("ill_last_cnt", {23'h0, cnt8}, 0);
        idle(1);

        // 2-bit address: wrap, then fill
        go2(2'd3);
        send(2, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0,
             1'b1, 8'd3, 32'h0022_1820);
        send(2, 5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1,
             1'b1, 8'd0, 32'h0022_1825);
        chk("wrap_done", {30'h0, done2, efu2}, 32'h2);
        idle(1);
        go2(2'd0);
        for (int i = 0; i < 4; i++) begin
            send(2, 5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0, 1'b0,
                 1'b1, 8'(i), 32'h2401_0000 | 32'(i));
        end
        chk("full_flag", {30'h0, done2, efu2}, 32'h3);
        chk("full_count", {29'h0, cnt2}, 4);
        chk("full_rdy", {31'h0, rdy2}, 0);
        send(2, 5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'h4, 26'h0, 1'b0,
             1'b0, 8'h0, 32'h0);
        chk("full_no5", {29'h0, cnt2}, 4);
        chk("full_idle", {30'h0, busy2, we2}, 0);
        idle(1);

        // reset the cycle after an accept
        go8(8'h50);
        send(8, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0,
             1'b1, 8'h50, 32'h0022_1820);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rrst_flags", {26'h0, busy8, rdy8, done8, we8, eil8, efu8}, 0);
        chk("rrst_addr", {24'h0, addr8}, 0);
        chk("rrst_data", wd8, 0);
        chk("rrst_cnt", {23'h0, cnt8}, 0);
        send(8, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1,
             1'b0, 8'h0, 32'h0);
        chk("rrst_nostart", {30'h0, busy8, we8}, 0);
        idle(1);

        // reset together with start and with an accept
        rst    = 1'b1;
        start8 = 1'b1;
        idle(1);
        start8 = 1'b0;
        rst    = 1'b0;
        chk("rst_over_start", {31'h0, busy8}, 0);
        go8(8'h60);
        rst = 1'b1;
        send(8, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1,
             1'b0, 8'h0, 32'h0);
        rst = 1'b0;
        chk("rst_drop_we", {30'h0, we8, busy8}, 0);
        idle(1);
        go8(8'h60);
        send(8, 5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1,
             1'b1, 8'h60, 32'h0022_1822);
        chk("resume_cnt", {23'h0, cnt8}, 1);
        idle(3);

        chk("q8_empty", 32'(q8.size()), 0);
        chk("q2_empty", 32'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
